opl3_host_port: RTL and testbench

- Host-facing front end of the OPL3 core. Decodes the four-byte OPL3 I/O window into register writes:
  - address port 0, data port 0 (bank 0);
  - address port 1, data port 1 (bank 1).
- Buffers register writes in a small FIFO and paces them onto the shared opl3_reg_wr bus.
- That bus feeds every register consumer in the core: operator/channel register banks, timers and the key-on LED indicators.
- Also serves status-register reads back to the host.

---
 rtl/opl3_pkg.sv | 25 ++
 rtl/opl3_reg_wr_fifo.sv | 60 ++++++
 rtl/opl3_host_port.sv | 110 +++++++++++
 tb/tb_opl3_host_port.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// opl3_pkg: shared types and constants for the OPL3 host front end.
//   opl3_reg_payload_t : bank/address/data triple held in the write FIFO (17 bits)
//   opl3_reg_wr_t      : register-write bus driven to every register consumer
//   OPL3_PORT_ADDR/DATA: values of host_addr[0] selecting address or data port
//   OPL3_STATUS_IDLE   : read value returned for non-status addresses
package opl3_pkg;

    typedef struct packed {
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_payload_t;

    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    localparam logic       OPL3_PORT_ADDR   = 1'b0;
    localparam logic       OPL3_PORT_DATA   = 1'b1;
    localparam logic [7:0] OPL3_STATUS_IDLE = 8'hFF;

endpackage

// File: rtl/opl3_reg_wr_fifo.sv
// opl3_reg_wr_fifo: synchronous FIFO of register-write payloads.
//   clk, ic_n : core clock, asynchronous active-low reset (empties the FIFO)
//   push, din : enqueue din; ignored when full (even if pop on the same edge)
//   pop, dout : dequeue; dout shows the head entry combinationally
//   full, empty, count : occupancy flags and entry count
module opl3_reg_wr_fifo
    import opl3_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       ic_n,
    input  logic                       push,
    input  opl3_reg_payload_t          din,
    input  logic                       pop,
    output opl3_reg_payload_t          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    opl3_reg_payload_t r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // Full is judged before the pop, so a push into a full FIFO is lost
    // even when an entry leaves on the same edge.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/opl3_host_port.sv
// opl3_host_port: host-facing front end of the OPL3 core.
//   clk, ic_n       : core clock, asynchronous active-low reset
//   host_wr/host_rd : single-cycle write/read strobes (write wins if both)
//   host_addr       : bit0 = address(0)/data(1) port, bit1 = bank select
//   host_din        : write data; host_dout: registered read data
//   status_in       : status byte returned on reads of address 0
//   opl3_reg_wr     : paced register-write bus (valid pulse + payload)
//   busy            : writes queued or pacing gap still running
//   overflow        : sticky, a data write was dropped on a full FIFO
module opl3_host_port
    import opl3_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned WR_GAP_CYCLES = 32
) (
    input  logic         clk,
    input  logic         ic_n,
    input  logic         host_wr,
    input  logic         host_rd,
    input  logic [1:0]   host_addr,
    input  logic [7:0]   host_din,
    output logic [7:0]   host_dout,
    input  logic [7:0]   status_in,
    output opl3_reg_wr_t opl3_reg_wr,
    output logic         busy,
    output logic         overflow
);

    localparam int unsigned GW = $clog2(WR_GAP_CYCLES + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Bank of a queued entry comes from the data write itself, so only the
    // address needs latching.
    logic [7:0]        r_addr;
    logic [GW-1:0]     r_gap;
    opl3_reg_wr_t      r_wr;
    logic [7:0]        r_dout;
    logic              r_ovf;

    logic              w_addr_wr;
    logic              w_data_wr;
    logic              w_rd;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    opl3_reg_payload_t w_push_data;
    opl3_reg_payload_t w_head;

    assign w_addr_wr   = host_wr && (host_addr[0] == OPL3_PORT_ADDR);
    assign w_data_wr   = host_wr && (host_addr[0] == OPL3_PORT_DATA);
    assign w_rd        = host_rd && !host_wr;
    assign w_pop       = !w_empty && (r_gap == '0);
    assign w_push_data = '{bank_num: host_addr[1], address: r_addr, data: host_din};

    opl3_reg_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .ic_n  (ic_n),
        .push  (w_data_wr),
        .din   (w_push_data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Address latch and sticky overflow
    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            r_addr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_addr_wr)            r_addr <= host_din;
            if (w_data_wr && w_full)  r_ovf  <= 1'b1;
        end
    end

    // Pacing: a pop launches one valid pulse and restarts the gap counter
    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            r_wr  <= '0;
            r_gap <= '0;
        end else if (w_pop) begin
            r_wr  <= '{valid: 1'b1, bank_num: w_head.bank_num,
                       address: w_head.address, data: w_head.data};
            r_gap <= GW'(WR_GAP_CYCLES - 1);
        end else begin
            r_wr.valid <= 1'b0;
            if (r_gap != '0) r_gap <= r_gap - 1'b1;
        end
    end

    // Read mux
    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            r_dout <= OPL3_STATUS_IDLE;
        end else if (w_rd) begin
            r_dout <= (host_addr == 2'b00) ? status_in : OPL3_STATUS_IDLE;
        end
    end

    assign opl3_reg_wr = r_wr;
    assign host_dout   = r_dout;
    assign overflow    = r_ovf;
    assign busy        = (w_count != '0) || (r_gap != '0);

endmodule

// File: tb/tb_opl3_host_port.sv
module tb_opl3_host_port;
    import opl3_pkg::*;

    logic         clk = 1'b0;
    logic         ic_n;
    logic         host_wr;
    logic         host_rd;
    logic [1:0]   host_addr;
    logic [7:0]   host_din;
    logic [7:0]   host_dout;
    logic [7:0]   status_in;
    opl3_reg_wr_t opl3_reg_wr;
    logic         busy;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         t;
        logic       b;
        logic [7:0] a;
        logic [7:0] d;
    } pulse_t;
    pulse_t pq[$];

    opl3_host_port #(
        .FIFO_DEPTH    (8),
        .WR_GAP_CYCLES (32)
    ) dut (
        .clk         (clk),
        .ic_n        (ic_n),
        .host_wr     (host_wr),
        .host_rd     (host_rd),
        .host_addr   (host_addr),
        .host_din    (host_din),
        .host_dout   (host_dout),
        .status_in   (status_in),
        .opl3_reg_wr (opl3_reg_wr),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse with the cycle it appeared in
    always @(negedge clk) begin
        if (opl3_reg_wr.valid === 1'b1)
            pq.push_back('{t: cyc, b: opl3_reg_wr.bank_num,
                           a: opl3_reg_wr.address, d: opl3_reg_wr.data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hwrite(input logic [1:0] a, input logic [7:0] d);
        host_wr   = 1'b1;
        host_addr = a;
        host_din  = d;
        tick();
        host_wr   = 1'b0;
    endtask

    task automatic hread(input logic [1:0] a);
        host_rd   = 1'b1;
        host_addr = a;
        tick();
        host_rd   = 1'b0;
    endtask

    task automatic wait_pq(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && pq.size() < n; i++) tick();
        chk(tag, pq.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_pulse(input int idx, input logic b, input logic [7:0] a,
                             input logic [7:0] d, input string tag);
        if (idx < pq.size()) begin
            chk({tag, "_bank"}, {31'd0, pq[idx].b}, {31'd0, b});
            chk({tag, "_addr"}, {24'd0, pq[idx].a}, {24'd0, a});
            chk({tag, "_data"}, {24'd0, pq[idx].d}, {24'd0, d});
        end else begin
            chk({tag, "_missing"}, idx, pq.size());
        end
    endtask

    initial begin
        int n;
        ic_n      = 1'b0;
        host_wr   = 1'b0;
        host_rd   = 1'b0;
        host_addr = 2'b00;
        host_din  = 8'h00;
        status_in = 8'hE0;
        repeat (3) tick();

        // Reset state
        chk("rst_bus",  {15'd0, opl3_reg_wr}, 32'd0);
        chk("rst_dout", {24'd0, host_dout}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf",  {31'd0, overflow}, 32'd0);
        ic_n = 1'b1;
        tick();

        // Single write: latency and busy tail
        hwrite(2'b00, 8'hB0);
        hwrite(2'b01, 8'h20);
        chk("lat_before", {31'd0, opl3_reg_wr.valid}, 32'd0);
        tick();
        chk("lat_bus", {15'd0, opl3_reg_wr}, {15'd0, 1'b1, 1'b0, 8'hB0, 8'h20});
        chk("lat_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("busy_tail", n, 31);
        chk("single_count", pq.size(), 1);
        pq.delete();

        // Three back-to-back data writes, paced 32 cycles apart
        hwrite(2'b00, 8'hB1);
        hwrite(2'b01, 8'h20);
        hwrite(2'b01, 8'h00);
        hwrite(2'b01, 8'h35);
        wait_pq(3, 200, "burst3_count");
        chk_pulse(0, 1'b0, 8'hB1, 8'h20, "b3_0");
        chk_pulse(1, 1'b0, 8'hB1, 8'h00, "b3_1");
        chk_pulse(2, 1'b0, 8'hB1, 8'h35, "b3_2");
        if (pq.size() == 3) begin
            chk("space_01", pq[1].t - pq[0].t, 32);
            chk("space_12", pq[2].t - pq[1].t, 32);
        end
        wait_idle(100, "idle_b3");
        pq.delete();

        // Bank 1 via port 1; then a bank-0 data write reuses the address
        hwrite(2'b10, 8'h05);
        hwrite(2'b11, 8'h01);
        wait_pq(1, 100, "bank1_count");
        chk_pulse(0, 1'b1, 8'h05, 8'h01, "bank1");
        hwrite(2'b01, 8'h02);
        wait_pq(2, 100, "bank0_count");
        chk_pulse(1, 1'b0, 8'h05, 8'h02, "bank_from_data");
        wait_idle(100, "idle_bank");
        pq.delete();

        // Overflow: burst of 10 while the gap counter is running
        hwrite(2'b01, 8'hAA);
        wait_pq(1, 20, "ovf_lead");
        for (int i = 0; i < 10; i++) hwrite(2'b01, 8'(i));
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        wait_pq(9, 400, "ovf_drain");
        repeat (100) tick();
        chk("ovf_total", pq.size(), 9);
        for (int i = 0; i < 8; i++) chk_pulse(i + 1, 1'b0, 8'h05, 8'(i), "ovf_order");
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        ic_n = 1'b0;
        tick();
        ic_n = 1'b1;
        tick();
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        pq.delete();

        // Reads
        hread(2'b00);
        chk("rd_status", {24'd0, host_dout}, 32'hE0);
        hread(2'b01);
        chk("rd_other", {24'd0, host_dout}, 32'hFF);
        hread(2'b00);
        repeat (3) tick();
        chk("rd_hold", {24'd0, host_dout}, 32'hE0);
        hwrite(2'b00, 8'h44);
        host_rd = 1'b1;
        hwrite(2'b01, 8'h77);
        host_rd = 1'b0;
        chk("rdwr_dout", {24'd0, host_dout}, 32'hE0);
        wait_pq(1, 50, "rdwr_count");
        chk_pulse(0, 1'b0, 8'h44, 8'h77, "rdwr_write");
        wait_idle(100, "idle_rd");
        pq.delete();

        // Reset mid-drain discards queued writes
        hwrite(2'b00, 8'h40);
        for (int i = 0; i < 4; i++) hwrite(2'b11, 8'h10 + 8'(i));
        wait_pq(2, 100, "mid_count");
        hread(2'b00);
        ic_n = 1'b0;
        #1;
        chk("mid_bus",  {15'd0, opl3_reg_wr}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_dout", {24'd0, host_dout}, 32'hFF);
        repeat (2) tick();
        ic_n = 1'b1;
        repeat (150) tick();
        chk("mid_nomore", pq.size(), 2);
        hwrite(2'b01, 8'h5A);
        wait_pq(3, 50, "post_count");
        chk_pulse(2, 1'b0, 8'h00, 8'h5A, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
